// File: rtl/i2c_data_rx_fifo_pkg.sv
// Shared types and helpers for the I2C slave data-phase receiver.
// Holds the FSM state encoding, the ACK bus level and the shifter bit-placement helper.
package i2c_data_rx_fifo_pkg;

    typedef enum logic [1:0] {
        StRxBits   = 2'd0,
        StAckWait  = 2'd1,
        StAckDrive = 2'd2,
        StNackSlot = 2'd3
    } rx_state_e;

    // SDA level seen on the bus while the receiver pulls it for an ACK.
    localparam logic I2C_ACK_LEVEL = 1'b0;

    function automatic int unsigned bit_index(input int unsigned cnt,
                                              input int unsigned width,
                                              input bit          msb_first);
        return msb_first ? (width - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/i2c_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received I2C words.
// The head is forced to zero while empty so the output is deterministic out of reset.
module i2c_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CountW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted when the head leaves on the same edge.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/i2c_data_rx_fifo.sv
// I2C slave data-phase receiver: shifts SDA into words, buffers them in a FIFO and
// drives the ACK slot a fixed number of clocks after the last data bit.
module i2c_data_rx_fifo
    import i2c_data_rx_fifo_pkg::*;
#(
    parameter int unsigned WORD_BITS  = 8,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned ACK_DELAY  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              en_i,
    input  logic                              sda_i,
    input  logic                              scl_sample_stb_i,
    output logic                              ack_drive_o,
    output logic                              nack_o,
    output logic [WORD_BITS-1:0]              rx_data_o,
    output logic                              rx_valid_o,
    input  logic                              rx_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count_o
);

    localparam int unsigned CntW = $clog2(WORD_BITS);

    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shifter_q, shifter_d;
    logic [WORD_BITS-1:0] word_next;
    logic [3:0]           delay_q, delay_d;
    logic                 nack_q;

    logic                 stb, last_bit, delay_done, room;
    logic                 push, pop, nack_set;
    logic                 fifo_full, fifo_empty;
    logic [CntW-1:0]      bit_idx;

    // Disable masks the strobe so a bit arriving as en_i falls is discarded.
    assign stb        = en_i & scl_sample_stb_i;
    assign last_bit   = (bit_cnt_q == CntW'(WORD_BITS - 1));
    assign delay_done = (delay_q == 4'(ACK_DELAY - 1));
    assign pop        = rx_valid_o & rx_ready_i;
    assign room       = ~fifo_full | pop;
    assign bit_idx    = CntW'(bit_index(32'(bit_cnt_q), WORD_BITS, MSB_FIRST != 0));

    always_comb begin
        word_next          = shifter_q;
        word_next[bit_idx] = sda_i;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StRxBits;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = StRxBits;
        end else begin
            unique case (state_q)
                StRxBits: begin
                    if (stb && last_bit) begin
                        state_d = room ? StAckWait : StNackSlot;
                    end
                end
                StAckWait: begin
                    if (delay_done) begin
                        state_d = StAckDrive;
                    end
                end
                StAckDrive, StNackSlot: begin
                    if (stb) begin
                        state_d = StRxBits;
                    end
                end
                default: state_d = StRxBits;
            endcase
        end
    end

    // FSM outputs; ack follows state so an async reset releases SDA immediately.
    always_comb begin
        ack_drive_o = (state_q == StAckDrive);
        push        = (state_q == StRxBits) & stb & last_bit & room;
        nack_set    = (state_q == StRxBits) & stb & last_bit & ~room;
    end

    // Datapath next state: shifter, bit counter and ACK delay counter.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shifter_d = shifter_q;
        delay_d   = '0;
        if (!en_i) begin
            bit_cnt_d = '0;
            shifter_d = '0;
        end else begin
            if ((state_q == StRxBits) && stb) begin
                if (last_bit) begin
                    bit_cnt_d = '0;
                    shifter_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shifter_d = word_next;
                end
            end
            if ((state_q == StAckWait) && !delay_done) begin
                delay_d = delay_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bit_cnt_q <= '0;
            shifter_q <= '0;
            delay_q   <= '0;
            nack_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shifter_q <= shifter_d;
            delay_q   <= delay_d;
            nack_q    <= nack_set;
        end
    end

    assign nack_o     = nack_q;
    assign rx_valid_o = ~fifo_empty;

    i2c_rx_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .data_i    (word_next),
        .pop_i     (pop),
        .data_o    (rx_data_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (rx_count_o)
    );

endmodule

// File: tb/tb_i2c_data_rx_fifo.sv
// Bench for i2c_data_rx_fifo: an MSB-first and an LSB-first instance share stimulus;
// a word table drives ACK/NACK/count checks and a scoreboard checks drained data.
module tb_i2c_data_rx_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       sda = 1'b0;
    logic       stb = 1'b0;
    logic       rx_ready = 1'b0;

    logic       ack_m, nack_m, valid_m;
    logic [7:0] data_m;
    logic [2:0] count_m;
    logic       ack_l, nack_l, valid_l;
    logic [7:0] data_l;
    logic [2:0] count_l;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    typedef struct {
        logic [7:0] word;
        bit         pop_at_push;
        bit         exp_ack;
        int         exp_count;
        bit         drain_after;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    i2c_data_rx_fifo #(
        .WORD_BITS  (8),
        .MSB_FIRST  (1),
        .ACK_DELAY  (4),
        .FIFO_DEPTH (4)
    ) u_dut_msb (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .en_i             (en),
        .sda_i            (sda),
        .scl_sample_stb_i (stb),
        .ack_drive_o      (ack_m),
        .nack_o           (nack_m),
        .rx_data_o        (data_m),
        .rx_valid_o       (valid_m),
        .rx_ready_i       (rx_ready),
        .rx_count_o       (count_m)
    );

    i2c_data_rx_fifo #(
        .WORD_BITS  (8),
        .MSB_FIRST  (0),
        .ACK_DELAY  (4),
        .FIFO_DEPTH (4)
    ) u_dut_lsb (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .en_i             (en),
        .sda_i            (sda),
        .scl_sample_stb_i (stb),
        .ack_drive_o      (ack_l),
        .nack_o           (nack_l),
        .rx_data_o        (data_l),
        .rx_valid_o       (valid_l),
        .rx_ready_i       (rx_ready),
        .rx_count_o       (count_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pair(input string name, input logic [31:0] act_m,
                              input logic [31:0] act_l, input logic [31:0] exp);
        check({name, "_msb"}, act_m, exp);
        check({name, "_lsb"}, act_l, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; optional consumer ready in the same cycle.
    task automatic strobe(input logic b, input logic rdy);
        sda      = b;
        stb      = 1'b1;
        rx_ready = rdy;
        tick();
        stb      = 1'b0;
        rx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit pop_at_push,
                             input bit exp_ack, input int exp_count);
        logic [7:0] em, el;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && pop_at_push) begin
                check_pair("head_valid_at_push", valid_m, valid_l, 1);
                em = q_m.pop_front();
                el = q_l.pop_front();
                check("head_data_at_push_msb", data_m, em);
                check("head_data_at_push_lsb", data_l, el);
            end
            strobe(w[i], (i == 0) && pop_at_push);
            if (i != 0) tick();
        end
        check_pair("nack_pulse", nack_m, nack_l, !exp_ack);
        check_pair("valid_after_word", valid_m, valid_l, 1);
        if (exp_ack) begin
            q_m.push_back(w);
            q_l.push_back(rev8(w));
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_pair("ack_early", ack_m, ack_l, 0);
            if (k == 1) check_pair("nack_one_cycle", nack_m, nack_l, 0);
        end
        tick();
        check_pair("ack_on_time", ack_m, ack_l, exp_ack);
        tick();
        tick();
        check_pair("ack_hold", ack_m, ack_l, exp_ack);
        strobe(1'b1, 1'b0);
        check_pair("ack_release", ack_m, ack_l, 0);
        tick();
        check_pair("count_after_word", count_m, count_l, exp_count);
    endtask

    task automatic drain();
        logic [7:0] em, el;
        rx_ready = 1'b1;
        for (int n = 0; n < 16 && (valid_m || valid_l); n++) begin
            if (q_m.size() == 0 || q_l.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_extra: got word %0h expected none", data_m);
                break;
            end
            em = q_m.pop_front();
            el = q_l.pop_front();
            check_pair("drain_valid", valid_m, valid_l, 1);
            check("drain_data_msb", data_m, em);
            check("drain_data_lsb", data_l, el);
            tick();
        end
        rx_ready = 1'b0;
        check("drain_left_msb", q_m.size(), 0);
        check("drain_left_lsb", q_l.size(), 0);
        check_pair("count_after_drain", count_m, count_l, 0);
    endtask

    initial begin
        logic [7:0] w;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 1'b0};
        vecs[1] = '{8'h12, 1'b0, 1'b1, 2, 1'b0};
        vecs[2] = '{8'h34, 1'b0, 1'b1, 3, 1'b0};
        vecs[3] = '{8'h56, 1'b0, 1'b1, 4, 1'b0};
        vecs[4] = '{8'h78, 1'b0, 1'b0, 4, 1'b1};
        vecs[5] = '{8'h9A, 1'b0, 1'b1, 1, 1'b0};
        vecs[6] = '{8'hBC, 1'b0, 1'b1, 2, 1'b0};
        vecs[7] = '{8'hDE, 1'b0, 1'b1, 3, 1'b0};
        vecs[8] = '{8'hF0, 1'b0, 1'b1, 4, 1'b0};
        vecs[9] = '{8'hC0, 1'b1, 1'b1, 4, 1'b1};

        // Reset state.
        repeat (3) tick();
        check_pair("rst_ack", ack_m, ack_l, 0);
        check_pair("rst_nack", nack_m, nack_l, 0);
        check_pair("rst_valid", valid_m, valid_l, 0);
        check_pair("rst_count", count_m, count_l, 0);
        check_pair("rst_data", data_m, data_l, 0);
        reset_n = 1'b1;
        tick();
        en = 1'b1;
        tick();

        // Word table: fill, overflow NACK, drain, then full FIFO with pop in push cycle.
        for (int v = 0; v < 10; v++) begin
            send_word(vecs[v].word, vecs[v].pop_at_push, vecs[v].exp_ack, vecs[v].exp_count);
            if (vecs[v].drain_after) drain();
        end

        // Disable mid-word, with a strobe on the falling cycle; FIFO must be kept.
        send_word(8'h11, 1'b0, 1'b1, 1);
        send_word(8'h22, 1'b0, 1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1, 1'b0);
            tick();
        end
        sda = 1'b1;
        stb = 1'b1;
        en  = 1'b0;
        tick();
        stb = 1'b0;
        tick();
        check_pair("count_while_disabled", count_m, count_l, 2);
        check_pair("ack_while_disabled", ack_m, ack_l, 0);
        en = 1'b1;
        tick();
        send_word(8'h3C, 1'b0, 1'b1, 3);
        drain();

        // Reset while driving ACK.
        w = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            strobe(w[i], 1'b0);
            if (i != 0) tick();
        end
        repeat (4) tick();
        check_pair("ack_before_reset", ack_m, ack_l, 1);
        #2 reset_n = 1'b0;
        #1;
        check_pair("async_rst_ack", ack_m, ack_l, 0);
        check_pair("async_rst_count", count_m, count_l, 0);
        check_pair("async_rst_valid", valid_m, valid_l, 0);
        check_pair("async_rst_data", data_m, data_l, 0);
        tick();
        reset_n = 1'b1;
        tick();
        send_word(8'hA5, 1'b0, 1'b1, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
